// File: rtl/vga_timing_pkg.sv
// Shared types, 640x480@60 default timing and helpers for the VGA raster timing generator.

package vga_timing_pkg;

  typedef enum logic [1:0] {
    PhaseActive,
    PhaseFp,
    PhaseSync,
    PhaseBp
  } phase_e;

  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;

  function automatic int unsigned total(input int unsigned active, input int unsigned fp,
                                        input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FP/SYNC/BP phase FSM, stepping on i_adv.

module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE   = DefHActive,
  parameter int unsigned FP       = DefHFp,
  parameter int unsigned SYNC     = DefHSync,
  parameter int unsigned BP       = DefHBp,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned CNT_W    = 12
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_adv,
  output logic [CNT_W-1:0] o_cnt,
  output phase_e           o_phase,
  output logic             o_sync,
  output logic             o_active,
  output logic             o_wrap
);

  localparam logic [CNT_W-1:0] EndActive = CNT_W'(ACTIVE - 1);
  localparam logic [CNT_W-1:0] EndFp     = CNT_W'(ACTIVE + FP - 1);
  localparam logic [CNT_W-1:0] EndSync   = CNT_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] LastCnt   = CNT_W'(total(ACTIVE, FP, SYNC, BP) - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;
  phase_e           r_phase;
  phase_e           w_phase_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_phase <= PhaseActive;
    end else begin
      r_cnt   <= w_cnt_d;
      r_phase <= w_phase_d;
    end
  end

  // Phase changes on the step that leaves the last position of the current phase.
  always_comb begin
    w_cnt_d   = r_cnt;
    w_phase_d = r_phase;
    if (i_adv) begin
      w_cnt_d = (r_cnt == LastCnt) ? '0 : r_cnt + CNT_W'(1);
      unique case (r_phase)
        PhaseActive: if (r_cnt == EndActive) w_phase_d = PhaseFp;
        PhaseFp:     if (r_cnt == EndFp)     w_phase_d = PhaseSync;
        PhaseSync:   if (r_cnt == EndSync)   w_phase_d = PhaseBp;
        PhaseBp:     if (r_cnt == LastCnt)   w_phase_d = PhaseActive;
        default:     w_phase_d = PhaseActive;
      endcase
    end
  end

  always_comb begin
    o_cnt    = r_cnt;
    o_phase  = r_phase;
    o_active = (r_phase == PhaseActive);
    o_sync   = (r_phase == PhaseSync) ? SYNC_POL : ~SYNC_POL;
    o_wrap   = (r_cnt == LastCnt);
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel clock-enable.
// Define VGA_TIMING_FRAME_CNT_EN to add the o_frame_cnt completed-frame counter.

module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DefHActive,
  parameter int unsigned H_FP       = DefHFp,
  parameter int unsigned H_SYNC     = DefHSync,
  parameter int unsigned H_BP       = DefHBp,
  parameter int unsigned V_ACTIVE   = DefVActive,
  parameter int unsigned V_FP       = DefVFp,
  parameter int unsigned V_SYNC     = DefVSync,
  parameter int unsigned V_BP       = DefVBp,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned FRAME_W    = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ce,
  output logic               o_h_sync,
  output logic               o_v_sync,
  output logic               o_de,
  output logic [CNT_W-1:0]   o_x,
  output logic [CNT_W-1:0]   o_y,
  output logic               o_line_start,
  output logic               o_frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [FRAME_W-1:0] o_frame_cnt
`endif
);

  localparam int unsigned HTotal = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTotal = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_zero_width
    $error("vga_timing_gen: zero-width timing parameter");
  end

  if (((HTotal - 1) >> CNT_W) != 0 || ((VTotal - 1) >> CNT_W) != 0 ||
      FRAME_W == 0) begin : g_bad_width
    $error("vga_timing_gen: CNT_W too narrow for the raster or FRAME_W is zero");
  end

  phase_e w_h_phase;
  phase_e w_v_phase;
  logic   w_h_active;
  logic   w_v_active;
  logic   w_h_wrap;
  logic   w_v_wrap;
  logic   w_line_wrap;
  logic   w_frame_wrap;
  logic   w_unused_phase;
  logic   r_line_start;
  logic   r_frame_start;

  assign w_line_wrap    = i_ce & w_h_wrap;
  assign w_frame_wrap   = w_line_wrap & w_v_wrap;
  assign w_unused_phase = ^{w_h_phase, w_v_phase};

  vga_axis_counter #(
    .ACTIVE   (H_ACTIVE),
    .FP       (H_FP),
    .SYNC     (H_SYNC),
    .BP       (H_BP),
    .SYNC_POL (H_SYNC_POL),
    .CNT_W    (CNT_W)
  ) u_h_axis (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_adv    (i_ce),
    .o_cnt    (o_x),
    .o_phase  (w_h_phase),
    .o_sync   (o_h_sync),
    .o_active (w_h_active),
    .o_wrap   (w_h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE   (V_ACTIVE),
    .FP       (V_FP),
    .SYNC     (V_SYNC),
    .BP       (V_BP),
    .SYNC_POL (V_SYNC_POL),
    .CNT_W    (CNT_W)
  ) u_v_axis (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_adv    (w_line_wrap),
    .o_cnt    (o_y),
    .o_phase  (w_v_phase),
    .o_sync   (o_v_sync),
    .o_active (w_v_active),
    .o_wrap   (w_v_wrap)
  );

  // Strobes are registered on the same edge the counters wrap, so they align with (0, y).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= w_line_wrap;
      r_frame_start <= w_frame_wrap;
    end
  end

  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;
  assign o_de          = w_h_active & w_v_active;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_W-1:0] r_frame_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_frame_cnt <= '0;
    end else if (w_frame_wrap) begin
      r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
    end
  end

  assign o_frame_cnt = r_frame_cnt;
`endif

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator. It produces horizontal/vertical sync, a data-enable, pixel coordinates and line/frame strobes for any mode described by active, front-porch, sync and back-porch widths. A clock-enable lets the block run from a system clock faster than the pixel rate. It sits between the clock/reset logic and the pixel renderer/DAC driver, and it supersedes the fixed 640x480 sync-pulse generator.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_SYNC_POL, 0, asserted level of h_sync (0 = negative pulse)
- V_SYNC_POL, 0, asserted level of v_sync
- CNT_W, 12, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- FRAME_W, 16, frame counter width (used only with VGA_TIMING_FRAME_CNT_EN)
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- ce  in  1  pixel advance enable; tie to 1 when clk is the pixel clock
- h_sync  out  1  horizontal sync, polarity per H_SYNC_POL
- v_sync  out  1  vertical sync, polarity per V_SYNC_POL
- de  out  1  high when (x, y) is inside the active area
- x  out  CNT_W  current column, 0..H_TOTAL-1
- y  out  CNT_W  current line, 0..V_TOTAL-1
- line_start  out  1  one-clk pulse when x wraps to 0
- frame_start  out  1  one-clk pulse when (x, y) wraps to (0, 0)
- frame_cnt  out  FRAME_W  completed frames (present only with the macro)

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise. Defaults give 800 x 525.
- The horizontal axis is a 4-state phase FSM: ACTIVE → FP → SYNC → BP → ACTIVE.
  - Each phase lasts its parameter width in ce-qualified cycles.
  - x counts within the line and wraps H_TOTAL-1 → 0.
- The vertical axis uses the same FSM, advancing only on ce with the horizontal wrap.
  - y wraps V_TOTAL-1 → 0.
- h_sync = H_SYNC_POL while the horizontal phase is SYNC (x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)), else ~H_SYNC_POL.
- v_sync is the same rule on y and V_* parameters. It changes only together with y.
- de = (x < H_ACTIVE) && (y < V_ACTIVE).
- All outputs are registered and mutually aligned: h_sync, v_sync, de, x and y always describe the same raster position.
- With ce=0, all outputs except the strobes hold their value. Strobes are 0 in any cycle without ce.
- line_start = 1 for exactly one clk, on the edge where ce moves x from H_TOTAL-1 to 0.
- frame_start = 1 for exactly one clk, on the edge where ce moves (H_TOTAL-1, V_TOTAL-1) to (0, 0). line_start is also 1 on that edge.
- Zero-width porch/sync parameters are illegal. An elaboration-time check must fail on zero widths or if CNT_W is too narrow.

## Timing
- Reset values:
  - x=0, y=0, both FSMs in ACTIVE, de=1
  - h_sync=~H_SYNC_POL, v_sync=~V_SYNC_POL
  - line_start=0, frame_start=0, frame_cnt=0
- Latency: outputs reflect a new position on the same clk edge that samples ce=1. There is no extra pipeline stage.
- rst has priority over ce. Reset mid-line or mid-frame returns to (0,0) on the next edge with no strobe.
- The first frame after reset produces no frame_start at (0,0). The first frame_start occurs at the first wrap.
- Frame period = H_TOTAL·V_TOTAL ce cycles. Line period = H_TOTAL ce cycles.

## Configuration
- VGA_TIMING_FRAME_CNT_EN defined:
  - The frame_cnt port and a FRAME_W register exist.
  - The register increments on each frame_start edge and wraps modulo 2^FRAME_W.
- Not defined: the port and register are absent. All other behaviour is identical.

## Structure
- Package vga_timing_pkg holds:
  - the phase enum typedef (ACTIVE, FP, SYNC, BP)
  - 640x480@60 default constants
  - a total(active, fp, sync, bp) function used in the width checks
- Sub-module vga_axis_counter is instantiated twice (horizontal, vertical).
  - Parameters: ACTIVE, FP, SYNC, BP, SYNC_POL, CNT_W.
  - Ports: clk, rst, adv, cnt, phase, sync, active, wrap.
  - For the horizontal instance adv = ce; for the vertical instance adv = ce & h_wrap.

## Test plan
- Small mode H=4/1/2/1, V=3/1/1/1, ce=1 → x cycles 0..7, y cycles 0..5. h_sync is asserted at x=5,6; v_sync at y=4; de only at x<4 && y<3. frame_start fires every 48 clks.
- Same mode with ce high every 3rd clk → same sequence stretched 3x. Strobes are 1 clk wide; outputs are stable on ce=0 clks.
- Defaults, ce=1 → line_start period 800, frame_start period 420000. h_sync low for 96 clks starting at x=656; v_sync low at lines 490–491.
- rst asserted at x=5, y=2 in the small mode → next edge gives x=0, y=0, de=1, syncs deasserted, no strobe. The next frame_start arrives 48 ce-cycles later.
- H_SYNC_POL=1, V_SYNC_POL=1 → sync pulses are inverted; all other outputs match the first test.
- With VGA_TIMING_FRAME_CNT_EN and FRAME_W=2 → frame_cnt goes 1,2,3,0 over four frames, updating on the frame_start edge.
